// File: rtl/decodificador_solicitudes.sv
// Request decoder for the elevator button interface.
//
// Takes the 4-bit button code (asynchronous to clk), synchronises it,
// debounces it and latches the request for each newly accepted code.
// Requests stay latched until the cabin serves them with the door open.
//
// State table:
//   IDLE   | synchronised code equals the last accepted code; waiting
//   CHECK  | a different code is being held; counting stable cycles
//   ACCEPT | candidate stable long enough; latch request, emit pulse
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   boton_pres      button code 0..15 (1..10 valid, 11..15 invalid)
//   piso_actual     current cabin floor 0..3
//   puerta_abierta  door open at piso_actual
//   dir_subida      cabin serving upward
//   dir_bajada      cabin serving downward
//   llamada_cabina  pending cabin calls, bit f = floor f+1
//   llamada_subir   pending hall up calls, bit f = floor f+1
//   llamada_bajar   pending hall down calls, bit f = floor f+2
//   pendiente       any request pending
//   nueva_solicitud one-cycle pulse, valid code accepted
//   codigo_invalido one-cycle pulse, code 11..15 accepted

module decodificador_solicitudes #(
  parameter int unsigned ESTABLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] boton_pres,
  input  logic [1:0] piso_actual,
  input  logic       puerta_abierta,
  input  logic       dir_subida,
  input  logic       dir_bajada,
  output logic [3:0] llamada_cabina,
  output logic [2:0] llamada_subir,
  output logic [2:0] llamada_bajar,
  output logic       pendiente,
  output logic       nueva_solicitud,
  output logic       codigo_invalido
);

  localparam logic [3:0] CNT_FIN = 4'(ESTABLE - 1);
  localparam logic [3:0] CNT_MAX = 4'(ESTABLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ACCEPT = 2'd2
  } estado_t;

  estado_t    estado, estado_sig;
  logic [3:0] s1, s2;
  logic [3:0] candidato, candidato_sig;
  logic [3:0] aceptado, aceptado_sig;
  logic [3:0] cnt, cnt_sig;
  logic [3:0] set_cab;
  logic [2:0] set_sub, set_baj;
  logic       nueva_sig, invalido_sig;
  logic [3:0] piso_onehot;
  logic [3:0] clr_cab;
  logic [2:0] clr_sub, clr_baj;
  logic       ambos;

  always_comb begin
    estado_sig    = estado;
    candidato_sig = candidato;
    aceptado_sig  = aceptado;
    cnt_sig       = cnt;
    set_cab       = '0;
    set_sub       = '0;
    set_baj       = '0;
    nueva_sig     = 1'b0;
    invalido_sig  = 1'b0;
    case (estado)
      IDLE: begin
        if (s2 != aceptado) begin
          candidato_sig = s2;
          cnt_sig       = 4'd1;
          estado_sig    = CHECK;
        end
      end
      CHECK: begin
        if (s2 == candidato) begin
          if (cnt == CNT_FIN) begin
            cnt_sig    = CNT_MAX;
            estado_sig = ACCEPT;
          end else begin
            cnt_sig = cnt + 4'd1;
          end
        end else if (s2 == aceptado) begin
          // bounced back to the code already in force: nothing new pressed
          estado_sig = IDLE;
        end else begin
          candidato_sig = s2;
          cnt_sig       = 4'd1;
        end
      end
      ACCEPT: begin
        aceptado_sig = candidato;
        estado_sig   = IDLE;
        nueva_sig    = 1'b1;
        case (candidato)
          4'd1:    set_cab[0] = 1'b1;
          4'd2:    set_cab[1] = 1'b1;
          4'd3:    set_cab[2] = 1'b1;
          4'd4:    set_cab[3] = 1'b1;
          4'd5:    set_sub[0] = 1'b1;
          4'd6:    set_baj[0] = 1'b1;
          4'd7:    set_sub[1] = 1'b1;
          4'd8:    set_baj[1] = 1'b1;
          4'd9:    set_sub[2] = 1'b1;
          4'd10:   set_baj[2] = 1'b1;
          4'd0:    nueva_sig  = 1'b0;
          default: begin
            nueva_sig    = 1'b0;
            invalido_sig = 1'b1;
          end
        endcase
      end
      default: estado_sig = IDLE;
    endcase
  end

  // Service clear. Floor 1 has only an up call and floor 4 only a down call,
  // so those are cleared regardless of direction. Both directions asserted
  // (illegal) clears like "no direction".
  always_comb begin
    ambos       = (dir_subida == dir_bajada);
    piso_onehot = 4'b0001 << piso_actual;
    clr_cab     = '0;
    clr_sub     = '0;
    clr_baj     = '0;
    if (puerta_abierta) begin
      clr_cab = piso_onehot;
      if (dir_subida || ambos || (piso_actual == 2'd0))
        clr_sub = piso_onehot[2:0];
      if (dir_bajada || ambos || (piso_actual == 2'd3))
        clr_baj = piso_onehot[3:1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1              <= '0;
      s2              <= '0;
      estado          <= IDLE;
      candidato       <= '0;
      aceptado        <= '0;
      cnt             <= '0;
      llamada_cabina  <= '0;
      llamada_subir   <= '0;
      llamada_bajar   <= '0;
      nueva_solicitud <= 1'b0;
      codigo_invalido <= 1'b0;
    end else begin
      s1              <= boton_pres;
      s2              <= s1;
      estado          <= estado_sig;
      candidato       <= candidato_sig;
      aceptado        <= aceptado_sig;
      cnt             <= cnt_sig;
      // clear has priority over a simultaneous set on the same bit
      llamada_cabina  <= (llamada_cabina | set_cab) & ~clr_cab;
      llamada_subir   <= (llamada_subir  | set_sub) & ~clr_sub;
      llamada_bajar   <= (llamada_bajar  | set_baj) & ~clr_baj;
      nueva_solicitud <= nueva_sig;
      codigo_invalido <= invalido_sig;
    end
  end

  assign pendiente = |{llamada_cabina, llamada_subir, llamada_bajar};

endmodule

// File: tb/tb_decodificador_solicitudes.sv
module tb_decodificador_solicitudes;

  localparam int ESTABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] boton_pres;
  logic [1:0] piso_actual;
  logic       puerta_abierta;
  logic       dir_subida;
  logic       dir_bajada;
  logic [3:0] llamada_cabina;
  logic [2:0] llamada_subir;
  logic [2:0] llamada_bajar;
  logic       pendiente;
  logic       nueva_solicitud;
  logic       codigo_invalido;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decodificador_solicitudes #(.ESTABLE(ESTABLE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .boton_pres     (boton_pres),
    .piso_actual    (piso_actual),
    .puerta_abierta (puerta_abierta),
    .dir_subida     (dir_subida),
    .dir_bajada     (dir_bajada),
    .llamada_cabina (llamada_cabina),
    .llamada_subir  (llamada_subir),
    .llamada_bajar  (llamada_bajar),
    .pendiente      (pendiente),
    .nueva_solicitud(nueva_solicitud),
    .codigo_invalido(codigo_invalido)
  );

  // Reference model: a code is taken once the sampled button value has been
  // the same for ESTABLE consecutive edges and differs from the last code
  // taken; its effect appears three edges later (two sync stages + accept).
  logic [3:0] m_cab;
  logic [2:0] m_sub, m_baj;
  logic       m_nueva, m_inv;
  logic [3:0] run_val, m_acc;
  int         run_len;
  int         edge_n = 0;
  int         ev_due[$];
  int         ev_code[$];

  always @(posedge clk) begin
    int c, f;
    bit amb;
    edge_n++;
    m_nueva = 1'b0;
    m_inv   = 1'b0;
    if (!rst_n) begin
      m_cab = '0; m_sub = '0; m_baj = '0;
      run_val = '0; run_len = 0; m_acc = '0;
      ev_due.delete(); ev_code.delete();
    end else begin
      while (ev_due.size() > 0 && ev_due[0] == edge_n) begin
        void'(ev_due.pop_front());
        c = ev_code.pop_front();
        if (c >= 1 && c <= 4) begin
          m_cab[c-1] = 1'b1; m_nueva = 1'b1;
        end else if (c >= 5 && c <= 10) begin
          if (c % 2 == 1) m_sub[(c-5)/2] = 1'b1;
          else            m_baj[(c-6)/2] = 1'b1;
          m_nueva = 1'b1;
        end else if (c >= 11) begin
          m_inv = 1'b1;
        end
      end
      if (puerta_abierta) begin
        f   = int'(piso_actual);
        amb = (dir_subida == dir_bajada);
        m_cab[f] = 1'b0;
        if (f <= 2 && (dir_subida || amb || f == 0)) m_sub[f] = 1'b0;
        if (f >= 1 && (dir_bajada || amb || f == 3)) m_baj[f-1] = 1'b0;
      end
      if (run_len > 0 && boton_pres == run_val) run_len++;
      else begin
        run_val = boton_pres;
        run_len = 1;
      end
      if (run_len == ESTABLE && run_val != m_acc) begin
        m_acc = run_val;
        ev_due.push_back(edge_n + 3);
        ev_code.push_back(int'(run_val));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    boton_pres = 4'd0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    boton_pres = 4'd9;
    repeat (3) tick();
    checks++;
    if ({llamada_cabina, llamada_subir, llamada_bajar, pendiente, nueva_solicitud, codigo_invalido} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {llamada_cabina, llamada_subir, llamada_bajar, pendiente, nueva_solicitud, codigo_invalido});
    end
    rst_n = 1'b1;
    boton_pres = 4'd0;
    tick();
  endtask

  task automatic test_latency();
    do_reset();
    boton_pres = 4'd3;
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (nueva_solicitud !== (e == ESTABLE + 3)) begin
        errors++; $display("FAIL latency_pulse edge=%0d got=%b", e, nueva_solicitud);
      end
      checks++;
      if (llamada_cabina !== ((e >= ESTABLE + 3) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL latency_cabina edge=%0d got=%b", e, llamada_cabina);
      end
      checks++;
      if (pendiente !== (e >= ESTABLE + 3)) begin
        errors++; $display("FAIL latency_pendiente edge=%0d got=%b", e, pendiente);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    logic [3:0] seq [6] = '{4'd3, 4'd3, 4'd7, 4'd7, 4'd3, 4'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      boton_pres = seq[i];
      tick();
      if (nueva_solicitud) pulses++;
    end
    boton_pres = 4'd7;
    repeat (12) begin
      tick();
      if (nueva_solicitud) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL glitch_pulses got=%0d exp=1", pulses); end
    checks++;
    if (llamada_subir !== 3'b010 || llamada_cabina !== 4'b0000 || llamada_bajar !== 3'b000) begin
      errors++;
      $display("FAIL glitch_bits got cab=%b sub=%b baj=%b exp cab=0000 sub=010 baj=000", llamada_cabina, llamada_subir, llamada_bajar);
    end
  endtask

  task automatic test_service_dir();
    do_reset();
    boton_pres = 4'd8;
    repeat (10) tick();
    checks++;
    if (llamada_bajar !== 3'b010) begin errors++; $display("FAIL service_set got=%b exp=010", llamada_bajar); end
    piso_actual = 2'd2; puerta_abierta = 1'b1; dir_subida = 1'b1; dir_bajada = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (llamada_bajar !== 3'b010) begin
        errors++; $display("FAIL service_up_keeps cycle=%0d got=%b exp=010", i, llamada_bajar);
      end
    end
    dir_subida = 1'b0; dir_bajada = 1'b1;
    tick();
    checks++;
    if (llamada_bajar !== 3'b000 || pendiente !== 1'b0) begin
      errors++; $display("FAIL service_down_clears got baj=%b pend=%b exp 000/0", llamada_bajar, pendiente);
    end
    puerta_abierta = 1'b0; dir_bajada = 1'b0; piso_actual = 2'd0;
  endtask

  task automatic test_invalid();
    int inv = 0, nue = 0;
    do_reset();
    boton_pres = 4'd12;
    repeat (10) begin
      tick();
      if (codigo_invalido) inv++;
      if (nueva_solicitud) nue++;
    end
    checks++;
    if (inv != 1 || nue != 0) begin errors++; $display("FAIL invalid_pulses got inv=%0d new=%0d exp 1/0", inv, nue); end
    checks++;
    if (pendiente !== 1'b0) begin errors++; $display("FAIL invalid_no_bits got pend=%b exp 0", pendiente); end
    boton_pres = 4'd2;
    repeat (10) tick();
    checks++;
    if (llamada_cabina !== 4'b0010) begin errors++; $display("FAIL invalid_then_valid got=%b exp=0010", llamada_cabina); end
  endtask

  task automatic test_clear_wins();
    int nue = 0;
    do_reset();
    piso_actual = 2'd0; puerta_abierta = 1'b1; dir_subida = 1'b0; dir_bajada = 1'b0;
    boton_pres = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (nueva_solicitud) nue++;
      checks++;
      if (llamada_cabina[0] !== 1'b0) begin errors++; $display("FAIL clear_wins cycle=%0d got=%b exp=0", i, llamada_cabina[0]); end
    end
    checks++;
    if (nue != 1) begin errors++; $display("FAIL clear_wins_pulse got=%0d exp=1", nue); end
    puerta_abierta = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    do_reset();
    boton_pres = 4'd4;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({llamada_cabina, llamada_subir, llamada_bajar, pendiente, nueva_solicitud, codigo_invalido} !== 13'd0) begin
      errors++; $display("FAIL reset_mid_outputs got=%b exp=0", {llamada_cabina, llamada_subir, llamada_bajar, pendiente, nueva_solicitud, codigo_invalido});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (first < 0 && llamada_cabina[3]) first = e;
    end
    checks++;
    if (first != ESTABLE + 3) begin errors++; $display("FAIL reset_mid_reaccept got edge=%0d exp=%0d", first, ESTABLE + 3); end
  endtask

  task automatic test_random();
    int prev = 0, code, hold;
    logic [12:0] got, exp;
    do_reset();
    repeat (4) tick();
    for (int s = 0; s < 90; s++) begin
      do code = $urandom_range(0, 15); while (code == prev);
      prev = code;
      // short glitches never reach ESTABLE; long holds outlast the accept cycle
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, ESTABLE - 1)
                                         : $urandom_range(ESTABLE + 2, ESTABLE + 8);
      boton_pres = 4'(code);
      for (int i = 0; i < hold; i++) begin
        piso_actual    = 2'($urandom_range(0, 3));
        puerta_abierta = ($urandom_range(0, 3) == 0);
        dir_subida     = 1'($urandom_range(0, 1));
        dir_bajada     = 1'($urandom_range(0, 1));
        tick();
        got = {llamada_cabina, llamada_subir, llamada_bajar, pendiente, nueva_solicitud, codigo_invalido};
        exp = {m_cab, m_sub, m_baj, |{m_cab, m_sub, m_baj}, m_nueva, m_inv};
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL random seg=%0d code=%0d got=%b exp=%b", s, code, got, exp);
        end
      end
    end
    puerta_abierta = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    boton_pres = 4'd0;
    piso_actual = 2'd0;
    puerta_abierta = 1'b0;
    dir_subida = 1'b0;
    dir_bajada = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_service_dir();
    test_invalid();
    test_clear_wins();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
